fifo_read_packer: RTL

//   Read-side consumer of the dual-clock FIFO, running entirely in the rclk domain.

---
 rtl/fifo_read_packer.sv | 115 +++++++++++
 1 files changed

// File: rtl/fifo_read_packer.sv
// Read-side FIFO consumer: packs LANES entries little-endian into one word.
// Partial words are emitted on idle timeout or on an explicit flush.
module fifo_read_packer #(
    parameter int DSIZE   = 8,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*LANES-1:0] out_data,
    output logic [LANES-1:0]       out_keep,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            word_count
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] ILAST = IW'(LANES - 1);
    localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t                 state, state_n;
    logic [IW-1:0]          idx, idx_n;
    logic [CW-1:0]          idle_cnt, idle_n;
    logic [DSIZE*LANES-1:0] data_q, data_n;
    logic [LANES-1:0]       keep_q, keep_n;
    logic                   valid_q, valid_n;
    logic [15:0]            wcnt, wcnt_n;
    logic                   pop;

    assign pop        = (state == FILL) & ~rempty;
    assign rinc       = pop & ~rrst;
    assign out_data   = data_q;
    assign out_keep   = keep_q;
    assign out_valid  = valid_q;
    assign word_count = wcnt;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state    <= FILL;
            idx      <= '0;
            idle_cnt <= '0;
            data_q   <= '0;
            keep_q   <= '0;
            valid_q  <= 1'b0;
            wcnt     <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            idle_cnt <= idle_n;
            data_q   <= data_n;
            keep_q   <= keep_n;
            valid_q  <= valid_n;
            wcnt     <= wcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        idle_n  = idle_cnt;
        data_n  = data_q;
        keep_n  = keep_q;
        valid_n = valid_q;
        wcnt_n  = wcnt;
        unique case (state)
            FILL: begin
                if (pop) begin
                    // a pop always restarts the idle timer, even at timeout
                    data_n[idx*DSIZE +: DSIZE] = rdata;
                    keep_n[idx] = 1'b1;
                    idle_n      = '0;
                    if (idx == ILAST || flush) begin
                        valid_n = 1'b1;
                        state_n = HOLD;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else if (idx != '0) begin
                    if (flush || idle_cnt == CLAST) begin
                        valid_n = 1'b1;
                        state_n = HOLD;
                        idx_n   = '0;
                        idle_n  = '0;
                    end else begin
                        idle_n = idle_cnt + 1'b1;
                    end
                end else begin
                    idle_n = '0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    data_n  = '0;
                    keep_n  = '0;
                    wcnt_n  = wcnt + 16'd1;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

endmodule
